// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory fetch bus between the PC/fetch sequencer and instruction memory.
// The sequencer (master) raises imem_req with imem_addr; memory (slave) answers with
// imem_ack and imem_rdata in the cycle the data is valid.
`timescale 1ns/1ps

interface pc_fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// PC register and instruction fetch sequencer.
// Owns the PC, fetches over a req/ack handshake and holds the fetched instruction
// for decode until it is consumed. Next-PC sources: sequential (+PC_INC), redirect
// (same-cycle or pending) and, when the EXC_VECTOR_EN macro is defined, the
// exception vector. Without EXC_VECTOR_EN the exc_req input is ignored.
`timescale 1ns/1ps

module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] PC_INC     = 32'd4,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_target,
  input  logic                   exc_req,
  pc_fetch_sequencer_if.master   imem,
  output logic                   inst_valid,
  output logic [31:0]            inst,
  output logic [31:0]            inst_pc,
  output logic [31:0]            pc_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        pendValid_q;
  logic [31:0] pendTarget_q;
  logic        req_q;
  logic        instValid_q;
  logic [31:0] inst_q;
  logic [31:0] instPc_q;

  logic [31:0] pcInc_d;
  logic [31:0] redirTarget_d;
  logic        fetchDiscard_d;

  // Redirect targets are always word aligned; the low two bits are dropped on capture.
  assign redirTarget_d = redirect_target & ~32'h0000_0003;

  // Sequential next PC, 32-bit modulo so the top word wraps to zero.
  assign pcInc_d = pc_q + PC_INC;

`ifdef EXC_VECTOR_EN
  // Set while a fetch abandoned by an exception is still waiting for its ack;
  // the bus keeps presenting the abandoned address until that ack retires it.
  logic        drain_q;
  logic [31:0] drainAddr_q;

  // Any redirect or an abandoned access means the returning data must be dropped.
  assign fetchDiscard_d = redirect_valid | pendValid_q | drain_q;

  assign imem.imem_addr = drain_q ? drainAddr_q : pc_q;

  // Tracks the access abandoned by an exception until memory acknowledges it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      drain_q     <= 1'b0;
      drainAddr_q <= 32'h0;
    end else if (state_q == S_FETCH && imem.imem_ack) begin
      drain_q <= 1'b0;
    end else if (exc_req && state_q == S_FETCH && !drain_q) begin
      drain_q     <= 1'b1;
      drainAddr_q <= pc_q;
    end
  end
`else
  logic [32:0] excUnused;

  // The exception path is absent in this build; exc_req and EXC_VECTOR go nowhere.
  assign excUnused      = {exc_req, EXC_VECTOR};
  assign fetchDiscard_d = redirect_valid | pendValid_q;
  assign imem.imem_addr = pc_q;
`endif

  assign imem.imem_req = req_q;
  assign inst_valid    = instValid_q;
  assign inst          = inst_q;
  assign inst_pc       = instPc_q;
  assign pc_out        = pc_q;

  // Fetch FSM: owns the PC, the pending redirect and all registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      pendValid_q  <= 1'b0;
      pendTarget_q <= 32'h0;
      req_q        <= 1'b0;
      instValid_q  <= 1'b0;
      inst_q       <= 32'h0;
      instPc_q     <= 32'h0;
    end else begin
`ifdef EXC_VECTOR_EN
      if (exc_req && state_q != S_IDLE) begin
        pc_q        <= EXC_VECTOR;
        pendValid_q <= 1'b0;
        instValid_q <= 1'b0;
        req_q       <= 1'b1;
        state_q     <= S_FETCH;
      end else
`endif
      case (state_q)
        S_IDLE: begin
          req_q   <= 1'b1;
          state_q <= S_FETCH;
        end

        S_FETCH: begin
          if (imem.imem_ack) begin
            if (fetchDiscard_d) begin
              if (redirect_valid) begin
                pc_q <= redirTarget_d;
              end else if (pendValid_q) begin
                pc_q <= pendTarget_q;
              end
              pendValid_q <= 1'b0;
              req_q       <= 1'b1;
              state_q     <= S_FETCH;
            end else begin
              inst_q      <= imem.imem_rdata;
              instPc_q    <= pc_q;
              pc_q        <= pcInc_d;
              instValid_q <= 1'b1;
              req_q       <= 1'b0;
              state_q     <= S_ISSUE;
            end
          end else if (redirect_valid) begin
            pendValid_q  <= 1'b1;
            pendTarget_q <= redirTarget_d;
          end
        end

        S_ISSUE: begin
          if (redirect_valid) begin
            pc_q <= redirTarget_d;
          end
          if (!stall) begin
            instValid_q <= 1'b0;
            req_q       <= 1'b1;
            state_q     <= S_FETCH;
          end
        end

        default: begin
          req_q       <= 1'b0;
          instValid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
